// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush/forward control for the 5-stage RISC-V
// pipeline, plus the sequencer for the fixed-latency multiply/divide unit.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
//
// MDU handshake: there is no ready/back-pressure. MulDivStart is a single-cycle
// pulse in the first EX cycle of an MDU op. The unit is then assumed to produce
// its result exactly MD_LATENCY cycles later. MulDivValid marks that cycle, and
// the op leaves EX at the end of it.
// md_state exposes the sequencer state (0 = IDLE, 1 = BUSY, 2 = DONE).
module hazard_controller #(
  parameter int MD_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1_D,
  input  logic [4:0] Rs2_D,
  input  logic [4:0] Rs1_E,
  input  logic [4:0] Rs2_E,
  input  logic [4:0] Rd_E,
  input  logic [4:0] Rd_M,
  input  logic [4:0] Rd_W,
  input  logic       RegWrite_M,
  input  logic       RegWrite_W,
  input  logic       ResultSrc_E0,
  input  logic       PCSrc_E,
  input  logic       MulDiv_E,
  output logic       Stall_F,
  output logic       Stall_D,
  output logic       Stall_E,
  output logic       Flush_D,
  output logic       Flush_E,
  output logic       Flush_M,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E,
  output logic       MulDivStart,
  output logic       MulDivValid,
  output logic [1:0] md_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // The counter is loaded in the start cycle. DONE follows the BUSY cycle
  // that sees cnt == 1, so stalls cover exactly MD_LATENCY cycles.
  localparam logic [3:0] CNT_LOAD = 4'(MD_LATENCY - 1);

  md_state_t  state;
  logic [3:0] cnt;

  logic       lw_stall;
  logic       md_stall;
  logic       md_start;
  logic       md_valid;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // The newest producer (MEM) wins over the older one (WB). x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       we_m,
                                         input logic [4:0] rd_m,
                                         input logic       we_w,
                                         input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Raw hazard terms: forwarding selects, load-use detect and MDU state decode.
  always_comb begin
    fwd_a    = fwd_sel(Rs1_E, RegWrite_M, Rd_M, RegWrite_W, Rd_W);
    fwd_b    = fwd_sel(Rs2_E, RegWrite_M, Rd_M, RegWrite_W, Rd_W);
    lw_stall = ResultSrc_E0 && (Rd_E != 5'd0) &&
               ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
    // MulDiv_E is only acted on in IDLE. In DONE the finishing op is still in EX.
    md_start = (state == IDLE) && MulDiv_E;
    md_stall = md_start || (state == BUSY);
    md_valid = (state == DONE);
  end

  // Output equations. All outputs are held at 0 while reset is asserted.
  always_comb begin
    Stall_F     = 1'b0;
    Stall_D     = 1'b0;
    Stall_E     = 1'b0;
    Flush_D     = 1'b0;
    Flush_E     = 1'b0;
    Flush_M     = 1'b0;
    ForwardA_E  = 2'b00;
    ForwardB_E  = 2'b00;
    MulDivStart = 1'b0;
    MulDivValid = 1'b0;
    md_state    = IDLE;
    if (rst) begin
      Stall_F     = lw_stall || md_stall;
      Stall_D     = lw_stall || md_stall;
      Stall_E     = md_stall;
      // The MDU result is not ready, so MEM receives bubbles while EX holds.
      Flush_M     = md_stall;
      // Never bubble EX while it holds an MDU op in flight.
      Flush_E     = (lw_stall || PCSrc_E) && !md_stall;
      Flush_D     = PCSrc_E;
      ForwardA_E  = fwd_a;
      ForwardB_E  = fwd_b;
      MulDivStart = md_start;
      MulDivValid = md_valid;
      md_state    = state;
    end
  end

  // MDU sequencer: IDLE -> BUSY (count down) -> DONE -> IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (MulDiv_E) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Free-running (wrapping) counts of front-end stall cycles and decode flushes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      StallCycles <= 32'd0;
      FlushCount  <= 32'd0;
    end else begin
      if (Stall_F) begin
        StallCycles <= StallCycles + 32'd1;
      end
      if (Flush_D) begin
        FlushCount <= FlushCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed testbench for hazard_controller (MD_LATENCY = 4).
module tb_hazard_controller;

  logic       clk;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic       RegWrite_M, RegWrite_W, ResultSrc_E0, PCSrc_E, MulDiv_E;
  logic       Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic       MulDivStart, MulDivValid;
  logic [1:0] md_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCycles, FlushCount;
`endif

  int n_total;
  int n_bad;

  hazard_controller #(.MD_LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .ResultSrc_E0(ResultSrc_E0), .PCSrc_E(PCSrc_E), .MulDiv_E(MulDiv_E),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E),
    .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_M(Flush_M),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .MulDivStart(MulDivStart), .MulDivValid(MulDivValid),
    .md_state(md_state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCycles(StallCycles), .FlushCount(FlushCount)
`endif
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running need finished");
    $fatal(1);
  end

  // Checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h need %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1_D = 5'd0; Rs2_D = 5'd0; Rs1_E = 5'd0; Rs2_E = 5'd0;
    Rd_E = 5'd0; Rd_M = 5'd0; Rd_W = 5'd0;
    RegWrite_M = 1'b0; RegWrite_W = 1'b0; ResultSrc_E0 = 1'b0;
    PCSrc_E = 1'b0; MulDiv_E = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall_f"}, 32'(Stall_F), 32'd0);
    check({tag, "_stall_d"}, 32'(Stall_D), 32'd0);
    check({tag, "_stall_e"}, 32'(Stall_E), 32'd0);
    check({tag, "_flush_d"}, 32'(Flush_D), 32'd0);
    check({tag, "_flush_e"}, 32'(Flush_E), 32'd0);
    check({tag, "_flush_m"}, 32'(Flush_M), 32'd0);
    check({tag, "_fwd_a"}, 32'(ForwardA_E), 32'd0);
    check({tag, "_fwd_b"}, 32'(ForwardB_E), 32'd0);
    check({tag, "_start"}, 32'(MulDivStart), 32'd0);
    check({tag, "_valid"}, 32'(MulDivValid), 32'd0);
    check({tag, "_state"}, 32'(md_state), 32'd0);
  endtask

  // Hand-computed MDU schedule, MD_LATENCY = 4, MulDiv_E high in cycles 0..9.
  // The second op starts in cycle 5 and completes in cycle 9.
  // Cycle 10 has MulDiv_E = 0.
  logic       exp_start [0:10] = '{1,0,0,0,0,1,0,0,0,0,0};
  logic       exp_stall [0:10] = '{1,1,1,1,0,1,1,1,1,0,0};
  logic       exp_valid [0:10] = '{0,0,0,0,1,0,0,0,0,1,0};
  logic [1:0] exp_state [0:10] = '{0,1,1,1,2,0,1,1,1,2,0};

  initial begin
    n_total = 0;
    n_bad   = 0;
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();

    // Reset: outputs are forced low even with hazards present.
    MulDiv_E = 1'b1; PCSrc_E = 1'b1;
    ResultSrc_E0 = 1'b1; Rd_E = 5'd7; Rs1_D = 5'd7;
    #1;
    check_all_zero("rst");
    clear_inputs();
    tick();
    rst = 1'b1;
    #1;
    check_all_zero("idle");

    // Forwarding: MEM beats WB. x0 is not forwarded. No write enable means no forward.
    RegWrite_M = 1'b1; Rd_M = 5'd5; RegWrite_W = 1'b1; Rd_W = 5'd5;
    Rs1_E = 5'd5; Rs2_E = 5'd5;
    #1;
    check("fwd_a_mem", 32'(ForwardA_E), 32'd2);
    check("fwd_b_mem", 32'(ForwardB_E), 32'd2);
    Rd_M = 5'd0;
    #1;
    check("fwd_a_wb", 32'(ForwardA_E), 32'd1);
    Rs2_E = 5'd6;
    #1;
    check("fwd_b_none", 32'(ForwardB_E), 32'd0);
    Rd_M = 5'd6; Rd_W = 5'd0; Rs1_E = 5'd0;
    #1;
    check("fwd_a_x0", 32'(ForwardA_E), 32'd0);
    check("fwd_b_mem6", 32'(ForwardB_E), 32'd2);
    RegWrite_M = 1'b0;
    #1;
    check("fwd_b_no_we", 32'(ForwardB_E), 32'd0);
    clear_inputs();

    // Load-use on Rs2_D.
    ResultSrc_E0 = 1'b1; Rd_E = 5'd7; Rs2_D = 5'd7;
    #1;
    check("lu_stall_f", 32'(Stall_F), 32'd1);
    check("lu_stall_d", 32'(Stall_D), 32'd1);
    check("lu_flush_e", 32'(Flush_E), 32'd1);
    check("lu_stall_e", 32'(Stall_E), 32'd0);
    check("lu_flush_m", 32'(Flush_M), 32'd0);
    check("lu_flush_d", 32'(Flush_D), 32'd0);
    tick();
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall_1", StallCycles, 32'd1);
`endif
    // A load whose destination is x0 is not a hazard.
    Rd_E = 5'd0; Rs2_D = 5'd0;
    #1;
    check("lu_x0_stall", 32'(Stall_F), 32'd0);
    check("lu_x0_flush", 32'(Flush_E), 32'd0);
    // A load that is not consumed by decode is not a hazard.
    Rd_E = 5'd9; Rs1_D = 5'd8; Rs2_D = 5'd10;
    #1;
    check("lu_nomatch", 32'(Stall_F), 32'd0);

    // A taken branch overlapping a load-use hazard.
    Rs1_D = 5'd9; PCSrc_E = 1'b1;
    #1;
    check("br_flush_d", 32'(Flush_D), 32'd1);
    check("br_flush_e", 32'(Flush_E), 32'd1);
    check("br_stall_d", 32'(Stall_D), 32'd1);
    tick();
`ifdef HAZARD_PERF_CNT_EN
    check("perf_flush_1", FlushCount, 32'd1);
    check("perf_stall_2", StallCycles, 32'd2);
`endif
    clear_inputs();
    PCSrc_E = 1'b1;
    #1;
    check("br_only_flush_e", 32'(Flush_E), 32'd1);
    check("br_only_stall", 32'(Stall_F), 32'd0);
    clear_inputs();
    tick();

    // Back-to-back MDU ops. A load-use in cycles 1..3 must not flush EX.
    for (int c = 0; c <= 10; c++) begin
      clear_inputs();
      MulDiv_E = (c <= 9);
      if (c >= 1 && c <= 3) begin
        ResultSrc_E0 = 1'b1; Rd_E = 5'd7; Rs1_D = 5'd7;
      end
      #1;
      check($sformatf("md%0d_start", c), 32'(MulDivStart), 32'(exp_start[c]));
      check($sformatf("md%0d_stall_f", c), 32'(Stall_F), 32'(exp_stall[c]));
      check($sformatf("md%0d_stall_d", c), 32'(Stall_D), 32'(exp_stall[c]));
      check($sformatf("md%0d_stall_e", c), 32'(Stall_E), 32'(exp_stall[c]));
      check($sformatf("md%0d_flush_m", c), 32'(Flush_M), 32'(exp_stall[c]));
      check($sformatf("md%0d_flush_e", c), 32'(Flush_E), 32'd0);
      check($sformatf("md%0d_valid", c), 32'(MulDivValid), 32'(exp_valid[c]));
      check($sformatf("md%0d_state", c), 32'(md_state), 32'(exp_state[c]));
      tick();
    end

    // Reset asserted during the second BUSY cycle abandons the op.
    clear_inputs();
    MulDiv_E = 1'b1;
    #1;
    check("rb_start", 32'(MulDivStart), 32'd1);
    tick();
    #1;
    check("rb_busy1", 32'(md_state), 32'd1);
    tick();
    rst = 1'b0;
    #1;
    check_all_zero("rb_rst");
    tick();
    rst = 1'b1;
    MulDiv_E = 1'b0;
    #1;
    check_all_zero("rb_after");
`ifdef HAZARD_PERF_CNT_EN
    check("rb_perf_stall", StallCycles, 32'd0);
    check("rb_perf_flush", FlushCount, 32'd0);
`endif
    // The FSM is back in IDLE, so a new MDU op starts at once.
    MulDiv_E = 1'b1;
    #1;
    check("rb_restart", 32'(MulDivStart), 32'd1);
    check("rb_restart_stall", 32'(Stall_E), 32'd1);
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
